// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, types and select/blanking helpers for the display scanner
//
// Purpose: common definitions imported by display_scan_mux.
// Ports:   none (package).
package display_pkg;

    localparam int DEFAULT_NDIGITS = 4;

    // Helpers work on a fixed maximum width; callers zero-extend their
    // NDIGITS-wide vectors in and truncate the results back down.
    localparam int MAX_DIGITS = 16;

    typedef logic [MAX_DIGITS-1:0]         digit_mask_t;
    typedef logic [4*MAX_DIGITS-1:0]       digit_vec_t;
    typedef logic [$clog2(MAX_DIGITS)-1:0] digit_idx_t;

    // One-hot digit select, inverted for active-low (common-anode) drive.
    function automatic digit_mask_t digit_sel(input digit_idx_t idx, input logic common_anode);
        digit_mask_t sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return common_anode ? ~sel : sel;
    endfunction

    // Bit k set when digit k is a leading zero: it and every higher digit
    // are 0 with no decimal point lit. Digit 0 is never blanked.
    function automatic digit_mask_t lz_mask(input digit_vec_t digits, input digit_mask_t dps);
        digit_mask_t blank;
        logic        all_zero;
        blank    = '0;
        all_zero = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero & (digits[4*k +: 4] == 4'h0) & ~dps[k];
            blank[k] = all_zero & (k != 0);
        end
        return blank;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - free-running divider producing one tick every DIV cycles
//
// Purpose: sets the dwell time of each digit slot.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   tick  out high in the cycle where the count equals DIV-1 (every cycle when DIV=1)
module scan_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - time-multiplexed 7-segment digit scanner with double-buffered value
//
// Purpose: walks the digits of a double-buffered hex value, presenting one
// nibble at a time to a shared segment decoder and driving digit select and
// decimal point. New values take effect only at frame boundaries.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   strobe: capture value/dp_in into the shadow buffer
//   value    in   4*NDIGITS hex digits, digit 0 in [3:0]
//   dp_in    in   NDIGITS decimal points, 1 = lit
//   nibble   out  current digit code for the decoder
//   digit_en out  one-hot digit select (active-low when COMMON_ANODE)
//   dp       out  decimal point of current digit (active-low when COMMON_ANODE)
//   pending  out  shadow buffer holds a value not yet displayed
//   frame    out  one-cycle pulse as a new frame starts
// NDIGITS must not exceed display_pkg::MAX_DIGITS.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NDIGITS      = DEFAULT_NDIGITS,
    parameter int DIV          = 50000,
    parameter int COMMON_ANODE = 1,
    parameter int BLANK_LZ     = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp_in,
    output logic [3:0]             nibble,
    output logic [NDIGITS-1:0]     digit_en,
    output logic                   dp,
    output logic                   pending,
    output logic                   frame
);

    localparam int                 IW       = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IW-1:0]      LAST_IDX = IW'(NDIGITS - 1);
    localparam logic               DP_OFF   = (COMMON_ANODE != 0);
    localparam logic [NDIGITS-1:0] EN_OFF   = {NDIGITS{DP_OFF}};

    logic                   tick;
    logic                   boundary;
    logic [NDIGITS-1:0]     blank_mask;

    logic [IW-1:0]          idx_q, idx_d;
    logic [4*NDIGITS-1:0]   act_val_q, act_val_d;
    logic [NDIGITS-1:0]     act_dp_q, act_dp_d;
    logic [4*NDIGITS-1:0]   sh_val_q, sh_val_d;
    logic [NDIGITS-1:0]     sh_dp_q, sh_dp_d;
    logic                   pending_q, pending_d;
    logic [3:0]             nibble_q, nibble_d;
    logic [NDIGITS-1:0]     digit_en_q, digit_en_d;
    logic                   dp_q, dp_d;
    logic                   frame_q, frame_d;

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        boundary = tick && (idx_q == LAST_IDX);

        idx_d = idx_q;
        if (tick) begin
            idx_d = boundary ? '0 : idx_q + IW'(1);
        end

        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        if (boundary && pending_q) begin
            act_val_d = sh_val_q;
            act_dp_d  = sh_dp_q;
        end

        // The boundary consumes the old shadow first; a load in the same
        // cycle then refills it and keeps pending set for the next frame.
        sh_val_d  = sh_val_q;
        sh_dp_d   = sh_dp_q;
        pending_d = pending_q & ~boundary;
        if (load) begin
            sh_val_d  = value;
            sh_dp_d   = dp_in;
            pending_d = 1'b1;
        end

        frame_d = boundary;

        // Outputs are computed from the pre-edge idx/active, giving one
        // cycle of latency behind the index.
        blank_mask = NDIGITS'(lz_mask(digit_vec_t'(act_val_q), digit_mask_t'(act_dp_q)));
        nibble_d   = act_val_q[{idx_q, 2'b00} +: 4];
        dp_d       = act_dp_q[idx_q] ^ DP_OFF;
        digit_en_d = NDIGITS'(digit_sel(digit_idx_t'(idx_q), COMMON_ANODE != 0));
        if ((BLANK_LZ != 0) && blank_mask[idx_q]) begin
            digit_en_d = EN_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            sh_val_q   <= '0;
            sh_dp_q    <= '0;
            pending_q  <= 1'b0;
            nibble_q   <= 4'h0;
            digit_en_q <= EN_OFF;
            dp_q       <= DP_OFF;
            frame_q    <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            sh_val_q   <= sh_val_d;
            sh_dp_q    <= sh_dp_d;
            pending_q  <= pending_d;
            nibble_q   <= nibble_d;
            digit_en_q <= digit_en_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
        end
    end

    assign nibble   = nibble_q;
    assign digit_en = digit_en_q;
    assign dp       = dp_q;
    assign pending  = pending_q;
    assign frame    = frame_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - self-checking bench for display_scan_mux
module tb_display_scan_mux;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           load;
    logic [4*N-1:0] value;
    logic [N-1:0]   dp_in;

    logic [3:0]     nib  [3];
    logic [N-1:0]   en   [3];
    logic           dpo  [3];
    logic           pend [3];
    logic           frm  [3];

    always #5 clk = ~clk;

    // dut0: DIV=4, common anode, no blanking
    display_scan_mux #(.NDIGITS(N), .DIV(4), .COMMON_ANODE(1), .BLANK_LZ(0)) u_a (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .nibble(nib[0]), .digit_en(en[0]), .dp(dpo[0]), .pending(pend[0]), .frame(frm[0])
    );
    // dut1: DIV=4, common anode, leading-zero blanking
    display_scan_mux #(.NDIGITS(N), .DIV(4), .COMMON_ANODE(1), .BLANK_LZ(1)) u_b (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .nibble(nib[1]), .digit_en(en[1]), .dp(dpo[1]), .pending(pend[1]), .frame(frm[1])
    );
    // dut2: DIV=1, common cathode, no blanking
    display_scan_mux #(.NDIGITS(N), .DIV(1), .COMMON_ANODE(0), .BLANK_LZ(0)) u_c (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .nibble(nib[2]), .digit_en(en[2]), .dp(dpo[2]), .pending(pend[2]), .frame(frm[2])
    );

    function automatic int cfg_div(input int c);
        return (c == 2) ? 1 : 4;
    endfunction
    function automatic bit cfg_ca(input int c);
        return (c != 2);
    endfunction
    function automatic bit cfg_bl(input int c);
        return (c == 1);
    endfunction

    // Reference model: digit slot derived from the edge count since reset.
    logic [15:0] m_act [3];
    logic [15:0] m_sh  [3];
    logic [3:0]  m_adp [3];
    logic [3:0]  m_sdp [3];
    logic        m_pend[3];
    logic [3:0]  x_nib [3];
    logic [3:0]  x_en  [3];
    logic        x_dp  [3];
    logic        x_pend[3];
    logic        x_frm [3];
    int          edge_n;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic model_reset();
        edge_n = 0;
        for (int c = 0; c < 3; c++) begin
            m_act[c] = '0; m_sh[c] = '0; m_adp[c] = '0; m_sdp[c] = '0; m_pend[c] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic ld, input logic [15:0] v, input logic [3:0] d);
        edge_n++;
        for (int c = 0; c < 3; c++) begin
            int         div;
            int         idx;
            bit         blank;
            logic [3:0] oh;
            div   = cfg_div(c);
            idx   = ((edge_n - 1) / div) % N;
            blank = cfg_bl(c) && (idx > 0) && ((m_act[c] >> (4 * idx)) == 0)
                    && ((m_adp[c] >> idx) == 0);
            oh    = 4'b0001 << idx;
            if (blank) oh = 4'b0000;
            x_nib[c] = m_act[c][4*idx +: 4];
            x_en[c]  = cfg_ca(c) ? ~oh : oh;
            x_dp[c]  = cfg_ca(c) ? ~m_adp[c][idx] : m_adp[c][idx];
            x_frm[c] = ((edge_n % (div * N)) == 0);
            if (x_frm[c]) begin
                if (m_pend[c]) begin
                    m_act[c] = m_sh[c];
                    m_adp[c] = m_sdp[c];
                end
                m_pend[c] = 1'b0;
            end
            if (ld) begin
                m_sh[c]   = v;
                m_sdp[c]  = d;
                m_pend[c] = 1'b1;
            end
            x_pend[c] = m_pend[c];
        end
    endtask

    task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d edge %0d: observed %h expected %h", tag, c, edge_n, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 3; c++) begin
            check("nibble",   c, 32'(nib[c]),  32'(x_nib[c]));
            check("digit_en", c, 32'(en[c]),   32'(x_en[c]));
            check("dp",       c, 32'(dpo[c]),  32'(x_dp[c]));
            check("pending",  c, 32'(pend[c]), 32'(x_pend[c]));
            check("frame",    c, 32'(frm[c]),  32'(x_frm[c]));
        end
    endtask

    task automatic check_reset();
        for (int c = 0; c < 3; c++) begin
            check("rst_nibble",   c, 32'(nib[c]),  32'h0);
            check("rst_digit_en", c, 32'(en[c]),   cfg_ca(c) ? 32'hF : 32'h0);
            check("rst_dp",       c, 32'(dpo[c]),  cfg_ca(c) ? 32'h1 : 32'h0);
            check("rst_pending",  c, 32'(pend[c]), 32'h0);
            check("rst_frame",    c, 32'(frm[c]),  32'h0);
        end
    endtask

    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
        load  = ld;
        value = v;
        dp_in = d;
        @(posedge clk);
        model_edge(ld, v, d);
        @(negedge clk);
        load = 1'b0;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 16'($urandom), 4'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        dp_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        // free run from reset
        run(32);

        // single load mid-frame
        run(6);
        step(1'b1, 16'h1A2F, 4'b0100);
        run(40);

        // last load before a boundary wins
        run(3);
        step(1'b1, 16'h1111, 4'b0000);
        run(2);
        step(1'b1, 16'h2222, 4'b0000);
        run(40);

        // load landing exactly on a dut0/dut1 boundary edge while pending
        step(1'b1, 16'h4444, 4'b0000);
        while (((edge_n + 1) % 16) != 0) run(1);
        step(1'b1, 16'h3333, 4'b0000);
        run(48);

        // leading-zero cases
        step(1'b1, 16'h0050, 4'b0000);
        run(40);
        step(1'b1, 16'h0000, 4'b0000);
        run(40);

        // randomized loads, biased towards zero nibbles
        for (int i = 0; i < 400; i++) begin
            logic [15:0] v;
            logic [3:0]  d;
            v = 16'($urandom);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 0) v[4*k +: 4] = 4'h0;
            end
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step($urandom_range(0, 7) == 0, v, d);
        end

        // asynchronous reset while a load is pending
        step(1'b1, 16'h9876, 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        model_reset();
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
